// File: rtl/inst_fetch_queue_if.sv
// ----------------------------------------------------------------------------
// inst_fetch_queue_if
// Bundles the fetch-side and decode-side signals of the instruction queue.
//   slave  : the queue itself (takes fetch packets, produces decode slots)
//   master : the environment (fetch stage + decode stage + flush source)
// Fetch side : flush_i, in_valid_i, in_enable_i, in_vaddr_i, in_inst_i,
//              in_predTake_i, in_predDest_i, in_hasException_i,
//              in_excCode_i, in_isRefill_i, iq_allowin_o
// Decode side: id_allowin_i, out_valid_o, out_inst*_o, out_pc*_o,
//              out_predTake_o, out_predDest*_o, out_hasException_o,
//              out_excCode*_o, out_isRefill_o
// ----------------------------------------------------------------------------
interface inst_fetch_queue_if;
    logic         flush_i;
    logic         in_valid_i;
    logic [3:0]   in_enable_i;
    logic [31:0]  in_vaddr_i;
    logic [127:0] in_inst_i;
    logic [3:0]   in_predTake_i;
    logic [127:0] in_predDest_i;
    logic         in_hasException_i;
    logic [4:0]   in_excCode_i;
    logic         in_isRefill_i;
    logic         iq_allowin_o;

    logic         id_allowin_i;
    logic [1:0]   out_valid_o;
    logic [31:0]  out_inst0_o;
    logic [31:0]  out_inst1_o;
    logic [31:0]  out_pc0_o;
    logic [31:0]  out_pc1_o;
    logic [1:0]   out_predTake_o;
    logic [31:0]  out_predDest0_o;
    logic [31:0]  out_predDest1_o;
    logic [1:0]   out_hasException_o;
    logic [4:0]   out_excCode0_o;
    logic [4:0]   out_excCode1_o;
    logic [1:0]   out_isRefill_o;

    modport slave (
        input  flush_i, in_valid_i, in_enable_i, in_vaddr_i, in_inst_i,
               in_predTake_i, in_predDest_i, in_hasException_i,
               in_excCode_i, in_isRefill_i, id_allowin_i,
        output iq_allowin_o, out_valid_o, out_inst0_o, out_inst1_o,
               out_pc0_o, out_pc1_o, out_predTake_o, out_predDest0_o,
               out_predDest1_o, out_hasException_o, out_excCode0_o,
               out_excCode1_o, out_isRefill_o
    );

    modport master (
        output flush_i, in_valid_i, in_enable_i, in_vaddr_i, in_inst_i,
               in_predTake_i, in_predDest_i, in_hasException_i,
               in_excCode_i, in_isRefill_i, id_allowin_i,
        input  iq_allowin_o, out_valid_o, out_inst0_o, out_inst1_o,
               out_pc0_o, out_pc1_o, out_predTake_o, out_predDest0_o,
               out_predDest1_o, out_hasException_o, out_excCode0_o,
               out_excCode1_o, out_isRefill_o
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// ----------------------------------------------------------------------------
// inst_fetch_queue
// Circular instruction queue between fetch (up to 4 words/cycle) and decode
// (up to 2 instructions/cycle). Enabled words of a fetch packet are compacted
// into consecutive entries starting at tail; decode sees entries head and
// head+1 combinationally. A flush empties the queue.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (priority over flush)
//   bus  - inst_fetch_queue_if.slave, fetch packet in / decode slots out
// ----------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    inst_fetch_queue_if.slave bus
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred_take;
        logic [31:0] pred_dest;
        logic        has_exc;
        logic [4:0]  exc_code;
        logic        is_refill;
    } entry_t;

    // Largest occupancy that still leaves room for a full 4-word packet.
    localparam logic [PTR_W:0] ALLOW_MAX = (PTR_W+1)'(DEPTH - 4);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             allowin;
    logic             enq_fire;
    logic [1:0]       first_word;
    logic [2:0]       pop_cnt;
    logic [2:0]       n_in;
    logic [1:0]       n_out;
    entry_t           slot_data [4];
    entry_t           entry_rd  [DEPTH];
    logic [PTR_W-1:0] head1;

    // Low address bits are replaced by the word index when forming PCs.
    logic unused_vaddr_lo;
    assign unused_vaddr_lo = ^bus.in_vaddr_i[3:0];

    assign allowin  = (count_q <= ALLOW_MAX);
    assign enq_fire = bus.in_valid_i && allowin && !bus.flush_i;

    // Lowest enabled word and number of enabled words.
    always_comb begin
        first_word = 2'd0;
        pop_cnt    = 3'd0;
        for (int k = 3; k >= 0; k--) begin
            if (bus.in_enable_i[k]) begin
                first_word = 2'(k);
            end
        end
        for (int k = 0; k < 4; k++) begin
            pop_cnt = pop_cnt + {2'b00, bus.in_enable_i[k]};
        end
    end

    // An exception packet collapses to a single marker entry.
    always_comb begin
        n_in = 3'd0;
        if (enq_fire) begin
            n_in = bus.in_hasException_i ? 3'd1 : pop_cnt;
        end
    end

    always_comb begin
        n_out = 2'd0;
        if (bus.id_allowin_i) begin
            if (count_q >= (PTR_W+1)'(2)) begin
                n_out = 2'd2;
            end else if (count_q != '0) begin
                n_out = 2'd1;
            end
        end
    end

    // Compacted packet: slot j carries word (first_word + j). Enables are
    // contiguous, so slots beyond n_in are never written.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gen_slot
            logic [1:0] word;
            assign word = first_word + 2'(gi);
            always_comb begin
                slot_data[gi]           = '0;
                slot_data[gi].pc        = {bus.in_vaddr_i[31:4], word, 2'b00};
                if (bus.in_hasException_i) begin
                    slot_data[gi].has_exc   = 1'b1;
                    slot_data[gi].exc_code  = bus.in_excCode_i;
                    slot_data[gi].is_refill = bus.in_isRefill_i;
                end else begin
                    slot_data[gi].inst      = bus.in_inst_i[{word, 5'b0} +: 32];
                    slot_data[gi].pred_take = bus.in_predTake_i[word];
                    slot_data[gi].pred_dest = bus.in_predDest_i[{word, 5'b0} +: 32];
                end
            end
        end
    endgenerate

    // Each entry decides for itself whether it lies in tail..tail+n_in-1;
    // the subtraction wraps modulo DEPTH so compaction crosses the end freely.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
            entry_t           ent_q, ent_d;
            logic [PTR_W-1:0] offset;
            assign offset = PTR_W'(gi) - tail_q;
            always_comb begin
                ent_d = ent_q;
                if ((PTR_W+1)'(offset) < (PTR_W+1)'(n_in)) begin
                    ent_d = slot_data[offset[1:0]];
                end
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    ent_q <= '0;
                end else begin
                    ent_q <= ent_d;
                end
            end
            assign entry_rd[gi] = ent_q;
        end
    endgenerate

    always_comb begin
        head_d  = head_q + PTR_W'(n_out);
        tail_d  = tail_q + PTR_W'(n_in);
        count_d = count_q + (PTR_W+1)'(n_in) - (PTR_W+1)'(n_out);
        if (bus.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head1 = head_q + PTR_W'(1);

    assign bus.iq_allowin_o       = allowin;
    assign bus.out_valid_o        = {count_q >= (PTR_W+1)'(2), count_q != '0};
    assign bus.out_inst0_o        = entry_rd[head_q].inst;
    assign bus.out_inst1_o        = entry_rd[head1].inst;
    assign bus.out_pc0_o          = entry_rd[head_q].pc;
    assign bus.out_pc1_o          = entry_rd[head1].pc;
    assign bus.out_predTake_o     = {entry_rd[head1].pred_take, entry_rd[head_q].pred_take};
    assign bus.out_predDest0_o    = entry_rd[head_q].pred_dest;
    assign bus.out_predDest1_o    = entry_rd[head1].pred_dest;
    assign bus.out_hasException_o = {entry_rd[head1].has_exc, entry_rd[head_q].has_exc};
    assign bus.out_excCode0_o     = entry_rd[head_q].exc_code;
    assign bus.out_excCode1_o     = entry_rd[head1].exc_code;
    assign bus.out_isRefill_o     = {entry_rd[head1].is_refill, entry_rd[head_q].is_refill};

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_queue_if bus();

    inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        take;
        logic [31:0] dest;
        logic        exc;
        logic [4:0]  code;
        logic        refill;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_slot(input int s, input exp_t e);
        logic [31:0] inst, pc, dest;
        logic        take, exc, refill;
        logic [4:0]  code;
        if (s == 0) begin
            inst = bus.out_inst0_o; pc = bus.out_pc0_o; dest = bus.out_predDest0_o;
            code = bus.out_excCode0_o;
        end else begin
            inst = bus.out_inst1_o; pc = bus.out_pc1_o; dest = bus.out_predDest1_o;
            code = bus.out_excCode1_o;
        end
        take   = bus.out_predTake_o[s];
        exc    = bus.out_hasException_o[s];
        refill = bus.out_isRefill_o[s];
        chk($sformatf("pc%0d", s), 160'(pc), 160'(e.pc));
        chk($sformatf("inst%0d", s), 160'(inst), 160'(e.inst));
        chk($sformatf("flags%0d", s), 160'({take, exc, code, refill}),
            160'({e.take, e.exc, e.code, e.refill}));
        if (!e.exc) chk($sformatf("dest%0d", s), 160'(dest), 160'(e.dest));
    endtask

    task automatic zero_check();
        chk("rst_zero",
            160'({bus.out_inst0_o, bus.out_inst1_o, bus.out_pc0_o, bus.out_pc1_o,
                  bus.out_predTake_o, bus.out_hasException_o, bus.out_isRefill_o,
                  bus.out_excCode0_o, bus.out_excCode1_o}),
            160'(0));
        chk("rst_dest", 160'({bus.out_predDest0_o, bus.out_predDest1_o}), 160'(0));
    endtask

    // Reference model of one accepted packet.
    task automatic push_pkt();
        int   first = 0;
        bit   found = 0;
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (bus.in_enable_i[k] && !found) begin
                first = k; found = 1;
            end
        end
        if (bus.in_hasException_i) begin
            e.inst = 0; e.take = 0; e.dest = 0; e.exc = 1;
            e.code = bus.in_excCode_i; e.refill = bus.in_isRefill_i;
            e.pc = {bus.in_vaddr_i[31:4], 4'(first * 4)};
            sb.push_back(e);
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (bus.in_enable_i[k]) begin
                    e.inst = bus.in_inst_i[32*k +: 32];
                    e.pc   = {bus.in_vaddr_i[31:4], 4'(k * 4)};
                    e.take = bus.in_predTake_i[k];
                    e.dest = bus.in_predDest_i[32*k +: 32];
                    e.exc = 0; e.code = 0; e.refill = 0;
                    sb.push_back(e);
                end
            end
        end
    endtask

    // One clock: compare outputs against the model mid-cycle, then advance
    // the model with the inputs the DUT sees at the coming edge.
    task automatic tick();
        int  n;
        bit  acc;
        @(negedge clk);
        n = sb.size();
        chk("valid", 160'(bus.out_valid_o), 160'({n >= 2, n >= 1}));
        chk("allowin", 160'(bus.iq_allowin_o), 160'(n <= DEPTH - 4));
        if (n >= 1) chk_slot(0, sb[0]);
        if (n >= 2) chk_slot(1, sb[1]);
        if (rst || bus.flush_i) begin
            sb.delete();
        end else begin
            acc = bus.in_valid_i && (n <= DEPTH - 4);
            if (bus.id_allowin_i) begin
                for (int i = 0; i < 2 && sb.size() > 0; i++) void'(sb.pop_front());
            end
            if (acc) push_pkt();
            if (bus.in_valid_i)
                $display("pkt vaddr=%h en=%b exc=%0d accepted=%0d occ=%0d",
                         bus.in_vaddr_i, bus.in_enable_i, bus.in_hasException_i, acc, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pkt(input logic [31:0] va, input logic [3:0] en,
                       input logic exc, input logic [4:0] code, input logic refill);
        bus.in_valid_i        = 1'b1;
        bus.in_vaddr_i        = va;
        bus.in_enable_i       = en;
        bus.in_inst_i         = {$urandom, $urandom, $urandom, $urandom};
        bus.in_predDest_i     = {$urandom, $urandom, $urandom, $urandom};
        bus.in_predTake_i     = 4'($urandom);
        bus.in_hasException_i = exc;
        bus.in_excCode_i      = code;
        bus.in_isRefill_i     = refill;
    endtask

    task automatic idle();
        bus.in_valid_i        = 1'b0;
        bus.in_enable_i       = 4'b0;
        bus.in_hasException_i = 1'b0;
        bus.in_excCode_i      = 5'd0;
        bus.in_isRefill_i     = 1'b0;
    endtask

    logic [3:0] masks [10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011,
                               4'b0110, 4'b1100, 4'b0111, 4'b1110, 4'b1111};

    initial begin
        rst = 1'b1;
        bus.flush_i = 1'b0;
        bus.id_allowin_i = 1'b0;
        bus.in_vaddr_i = '0;
        bus.in_inst_i = '0;
        bus.in_predDest_i = '0;
        bus.in_predTake_i = '0;
        idle();
        @(posedge clk); #1;
        tick();
        rst = 1'b0;
        zero_check();

        // Aligned full packet, no decode.
        pkt(32'hBFC0_0000, 4'b1111, 0, 5'd0, 0); tick();
        idle(); tick();
        chk("pc0_abs", 160'(bus.out_pc0_o), 160'(32'hBFC0_0000));
        chk("pc1_abs", 160'(bus.out_pc1_o), 160'(32'hBFC0_0004));
        bus.id_allowin_i = 1'b1; repeat (3) tick(); bus.id_allowin_i = 1'b0;

        // Unaligned two-word packet, then drained in one cycle.
        pkt(32'h8000_0008, 4'b1100, 0, 5'd0, 0); tick();
        idle(); bus.id_allowin_i = 1'b1; tick(); tick(); bus.id_allowin_i = 1'b0;

        // Exception packet collapses to one entry at the lowest enabled word.
        pkt(32'h1000_0000, 4'b0110, 1, 5'h02, 1); tick();
        idle(); tick();
        chk("exc_pc", 160'(bus.out_pc0_o), 160'(32'h1000_0004));
        bus.id_allowin_i = 1'b1; tick(); tick(); bus.id_allowin_i = 1'b0;
        // Exception with empty mask uses word 0.
        pkt(32'h2000_0000, 4'b0000, 1, 5'h0A, 0); tick();
        idle(); bus.id_allowin_i = 1'b1; tick(); tick(); bus.id_allowin_i = 1'b0;

        // Fill to full; the fifth packet must be dropped.
        for (int i = 0; i < 5; i++) begin
            pkt(32'h0040_0000 + 32'(i * 16), 4'b1111, 0, 5'd0, 0); tick();
        end
        idle(); tick();
        bus.id_allowin_i = 1'b1; repeat (9) tick(); bus.id_allowin_i = 1'b0;

        // Wrap: advance both pointers to 14, then a 4-word packet straddles the end.
        bus.flush_i = 1'b1; tick(); bus.flush_i = 1'b0;
        bus.id_allowin_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pkt(32'h0050_0000 + 32'(i * 16), 4'b1111, 0, 5'd0, 0); tick();
        end
        pkt(32'h0050_0030, 4'b0011, 0, 5'd0, 0); tick();
        idle(); repeat (8) tick();
        bus.id_allowin_i = 1'b0;
        pkt(32'h0060_0000, 4'b1111, 0, 5'd0, 0); tick();
        idle(); tick();
        bus.id_allowin_i = 1'b1; repeat (3) tick(); bus.id_allowin_i = 1'b0;

        // Flush beats same-cycle enqueue and dequeue with 7 entries held.
        pkt(32'h0070_0000, 4'b1111, 0, 5'd0, 0); tick();
        pkt(32'h0070_0010, 4'b0111, 0, 5'd0, 0); tick();
        pkt(32'h0070_0020, 4'b1111, 0, 5'd0, 0);
        bus.id_allowin_i = 1'b1; bus.flush_i = 1'b1; tick();
        bus.flush_i = 1'b0; bus.id_allowin_i = 1'b0; idle(); tick();

        // Reset together with flush returns to reset state.
        pkt(32'h0080_0000, 4'b1111, 0, 5'd0, 0); tick();
        pkt(32'h0080_0010, 4'b1111, 0, 5'd0, 0);
        rst = 1'b1; bus.flush_i = 1'b1; tick();
        rst = 1'b0; bus.flush_i = 1'b0; idle();
        zero_check();
        tick();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 9) == 0)
                    pkt($urandom, masks[$urandom_range(0, 9)], 1, 5'($urandom), 1'($urandom));
                else
                    pkt($urandom, masks[$urandom_range(0, 9)], 0, 5'd0, 0);
            end else begin
                idle();
            end
            bus.id_allowin_i = 1'($urandom_range(0, 2) != 0);
            bus.flush_i      = ($urandom_range(0, 40) == 0);
            tick();
        end
        idle(); bus.flush_i = 1'b0; bus.id_allowin_i = 1'b1;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Instruction queue directly downstream of the second cache-trace fetch stage. Each cycle it accepts one fetch packet of up to 4 words and compacts its enabled words into a circular buffer. It presents up to 2 instructions per cycle, in program order, to the decode stage. It decouples fetch bandwidth (4/cycle) from decode bandwidth (2/cycle) and is emptied by pipeline cancellation.

Parameters:
DEPTH, 16, number of single-instruction entries; must be a power of 2 and at least 8.
PTR_W, 4, log2(DEPTH); width of the head and tail pointers.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
flush_i  in  1  cancel: OR of branch-mismatch, exception and branch-recovery flushes.
in_valid_i  in  1  fetch packet valid; driven by the upstream valid, which already excludes cancelled packets.
in_enable_i  in  4  per-word enable; set bits are contiguous.
in_vaddr_i  in  32  packet address; word k has PC {in_vaddr_i[31:4], k[1:0], 2'b00}.
in_inst_i  in  128  4 instruction words; word k is bits [32k+31:32k].
in_predTake_i  in  4  per-word predicted-taken flag.
in_predDest_i  in  128  per-word predicted target, same layout as in_inst_i.
in_hasException_i  in  1  packet carries a fetch exception.
in_excCode_i  in  5  exception code.
in_isRefill_i  in  1  TLB refill exception.
iq_allowin_o  out  1  queue can take a full packet; high when free entries >= 4.
id_allowin_i  in  1  decode accepts the outputs this cycle.
out_valid_o  out  2  bit0 = slot0 valid, bit1 = slot1 valid; bit1 implies bit0.
out_inst0_o / out_inst1_o  out  32 each  instructions.
out_pc0_o / out_pc1_o  out  32 each  PCs.
out_predTake_o  out  2  per-slot predicted taken.
out_predDest0_o / out_predDest1_o  out  32 each  predicted targets.
out_hasException_o  out  2  per-slot exception flag.
out_excCode0_o / out_excCode1_o  out  5 each  exception codes.
out_isRefill_o  out  2  per-slot refill flag.

Behaviour:
- Storage: DEPTH entries, each holding {inst, pc, predTake, predDest, hasException, excCode, isRefill}. Pointers head and tail are PTR_W bits and wrap modulo DEPTH. count is PTR_W+1 bits.
- Outputs are combinational reads of entries head and head+1 (mod DEPTH), so there is no added latency. out_valid_o = {count>=2, count>=1}.
- Dequeue: when id_allowin_i is high, head advances by the number of valid output slots (0, 1 or 2). Dequeue with count==0 has no effect.
- Enqueue condition: in_valid_i && iq_allowin_o. in_valid_i while iq_allowin_o is low is dropped; upstream must hold the packet.
- Enqueue without exception: n = popcount(in_enable_i) entries are written at tail..tail+n-1, lowest enabled word first. tail advances by n. in_enable_i==0 writes nothing.
- Enqueue with exception: exactly one entry is written, using the PC of the lowest enabled word (word 0 if the mask is 0). Its inst is 32'h0, predTake 0, hasException 1, and excCode/isRefill are taken from the inputs.
- Same-cycle enqueue and dequeue are both applied: count_next = count + n_in - n_out. Writes never hit entries being read, because free >= 4 is guaranteed at enqueue.
- Wrap-around: compaction crosses the DEPTH-1 -> 0 boundary transparently.
- Flush priority: flush_i beats same-cycle enqueue and dequeue. On flush, head, tail and count are cleared to 0 next cycle, and the packet on the flushing cycle is discarded.
- Reset: rst has priority over flush_i. head=tail=count=0, so out_valid_o=2'b00 and iq_allowin_o=1.
- Reset values of the other outputs: all data outputs are driven from entry storage. Entry storage is reset to zero, so every output is 0 after reset.
- Reset asserted mid-stream: contents are lost. No packet is accepted in the reset cycle.
- Full boundary: count in DEPTH-3..DEPTH gives iq_allowin_o=0. The queue never overflows.

Test Plan:
- Reset, then one packet with vaddr=0xBFC00000, enable=4'b1111, no decode -> count=4, out_pc0=0xBFC00000, out_pc1=0xBFC00004, out_valid=2'b11.
- Unaligned packet with vaddr=0x80000008, enable=4'b1100 -> 2 entries, pc0=0x80000008, pc1=0x8000000C. One cycle later with id_allowin=1 -> count=0, out_valid=2'b00.
- Exception packet with enable=4'b0110, excCode=5'h02, isRefill=1 -> exactly 1 entry: pc=vaddr+4, inst=0, out_hasException=2'b01, excCode0=2.
- Fill with 4-word packets, id_allowin=0 -> after 3 packets count=12 and iq_allowin=1. After the 4th, count=16 and iq_allowin=0; a 5th in_valid is not enqueued and count stays 16.
- Wrap: pre-advance head and tail to 14, enqueue 4 words -> entries 14,15,0,1 hold them in order. Dequeue 2/cycle for 2 cycles -> PCs emerge in order and count returns to 0.
- flush_i in the same cycle as in_valid_i and id_allowin_i with count=7 -> next cycle count=0 and out_valid=0; rst and flush together -> reset state.
